// File: rtl/lc3_control.sv
// lc3_control: Moore-style sequencer for the LC-3 datapath.
//
// Every state drives all register load enables, mux selects and bus gates.
// Memory strobes (mem_oe / mem_we) are held for MEM_WAIT cycles, timed by an
// internal wait counter that restarts on entry to each memory state.
//
// Parameters
//   MEM_WAIT      cycles a memory strobe is held per access (1..15)
// Ports
//   clk           sole clock, rising edge
//   reset         synchronous, active-low
//   run           level; starts execution from HALTED, sampled at instruction end
//   continue_i    level; releases PAUSE
//   ir            instruction register contents
//   ben           registered branch enable from the NZP block
//   ld_*          register load enables (MAR, MDR, IR, BEN, CC, REG, PC, LED)
//   bus_sel       one-hot bus gate: 0001 PC, 0010 ALU, 0100 MDR, 1000 MARMUX
//   pcmux_sel     00 PC+1, 01 bus, 10 address adder
//   drmux_sel     0 IR[11:9], 1 R7
//   sr1mux_sel    0 IR[11:9], 1 IR[8:6]
//   sr2mux_sel    0 SR2 register, 1 SEXT(IR[4:0])
//   addr1mux_sel  0 PC, 1 SR1
//   addr2mux_sel  00 zero, 01 off6, 10 off9, 11 off11
//   aluk          00 ADD, 01 AND, 10 NOT, 11 PASS A
//   mio_en        1 MDR loads from memory, 0 from bus
//   mem_oe/mem_we memory read / write strobes
module lc3_control #(
  parameter int unsigned MEM_WAIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        continue_i,
  input  logic [15:0] ir,
  input  logic        ben,
  output logic        ld_mar,
  output logic        ld_mdr,
  output logic        ld_ir,
  output logic        ld_ben,
  output logic        ld_cc,
  output logic        ld_reg,
  output logic        ld_pc,
  output logic        ld_led,
  output logic [3:0]  bus_sel,
  output logic [1:0]  pcmux_sel,
  output logic        drmux_sel,
  output logic        sr1mux_sel,
  output logic        sr2mux_sel,
  output logic        addr1mux_sel,
  output logic [1:0]  addr2mux_sel,
  output logic [1:0]  aluk,
  output logic        mio_en,
  output logic        mem_oe,
  output logic        mem_we
);

  localparam logic [3:0] WaitLast = 4'(MEM_WAIT - 1);

  localparam logic [3:0] BusPc     = 4'b0001;
  localparam logic [3:0] BusAlu    = 4'b0010;
  localparam logic [3:0] BusMdr    = 4'b0100;
  localparam logic [3:0] BusMarmux = 4'b1000;

  localparam logic [1:0] PcPlus1 = 2'b00;
  localparam logic [1:0] PcAdder = 2'b10;

  localparam logic [1:0] Addr2Zero  = 2'b00;
  localparam logic [1:0] Addr2Off6  = 2'b01;
  localparam logic [1:0] Addr2Off9  = 2'b10;
  localparam logic [1:0] Addr2Off11 = 2'b11;

  localparam logic [1:0] AluAdd  = 2'b00;
  localparam logic [1:0] AluAnd  = 2'b01;
  localparam logic [1:0] AluNot  = 2'b10;
  localparam logic [1:0] AluPass = 2'b11;

  typedef enum logic [4:0] {
    StHalted,
    StFetch1,
    StFetch2,
    StFetch3,
    StDecode,
    StAdd,
    StAnd,
    StNot,
    StBr1,
    StBr2,
    StJmp,
    StJsr1,
    StJsr2,
    StMemAddr,
    StLdr2,
    StLdr3,
    StStr2,
    StStr3,
    StMemEnd,
    StPause1,
    StPause2
  } state_e;

  state_e     state_q, state_d;
  state_e     end_state;
  logic [3:0] wait_q, wait_d;
  logic       mem_last;
  logic       in_mem_state;

  // Only the opcode, the immediate flag and the LDR/STR split are decoded here.
  logic unused_ir;
  assign unused_ir = ^{ir[11:6], ir[4:0]};

  assign mem_last  = (wait_q == WaitLast);
  assign end_state = run ? StFetch1 : StHalted;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHalted:  if (run) state_d = StFetch1;
      StFetch1:  state_d = StFetch2;
      StFetch2:  if (mem_last) state_d = StFetch3;
      StFetch3:  state_d = StDecode;
      StDecode: begin
        case (ir[15:12])
          4'b0001: state_d = StAdd;
          4'b0101: state_d = StAnd;
          4'b1001: state_d = StNot;
          4'b0000: state_d = StBr1;
          4'b1100: state_d = StJmp;
          4'b0100: state_d = StJsr1;
          4'b0110,
          4'b0111: state_d = StMemAddr;
          4'b1101: state_d = StPause1;
          default: state_d = end_state;  // undefined opcode acts as NOP
        endcase
      end
      StAdd, StAnd, StNot, StJmp, StBr2, StJsr2: state_d = end_state;
      StBr1:     state_d = ben ? StBr2 : end_state;
      StJsr1:    state_d = StJsr2;
      // ir[12] separates STR (0111) from LDR (0110).
      StMemAddr: state_d = ir[12] ? StStr2 : StLdr2;
      StLdr2:    if (mem_last) state_d = StLdr3;
      StLdr3:    state_d = StMemEnd;
      StStr2:    state_d = StStr3;
      StStr3:    if (mem_last) state_d = StMemEnd;
      // Idle recovery cycle after a data access before the next fetch strobe.
      StMemEnd:  state_d = end_state;
      StPause1:  if (continue_i) state_d = StPause2;
      StPause2:  if (!continue_i) state_d = end_state;
      default:   state_d = StHalted;
    endcase
  end

  // Counter restarts at 0 whenever a memory state is entered and counts while held.
  always_comb begin
    in_mem_state = (state_d == StFetch2) || (state_d == StLdr2) || (state_d == StStr3);
    wait_d       = 4'd0;
    if (in_mem_state && (state_d == state_q)) begin
      wait_d = wait_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StHalted;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Output decode: everything defaults to 0, each state raises only what it needs.
  always_comb begin
    ld_mar       = 1'b0;
    ld_mdr       = 1'b0;
    ld_ir        = 1'b0;
    ld_ben       = 1'b0;
    ld_cc        = 1'b0;
    ld_reg       = 1'b0;
    ld_pc        = 1'b0;
    ld_led       = 1'b0;
    bus_sel      = 4'b0000;
    pcmux_sel    = PcPlus1;
    drmux_sel    = 1'b0;
    sr1mux_sel   = 1'b0;
    sr2mux_sel   = 1'b0;
    addr1mux_sel = 1'b0;
    addr2mux_sel = Addr2Zero;
    aluk         = AluAdd;
    mio_en       = 1'b0;
    mem_oe       = 1'b0;
    mem_we       = 1'b0;
    unique case (state_q)
      StFetch1: begin
        bus_sel   = BusPc;
        ld_mar    = 1'b1;
        pcmux_sel = PcPlus1;
        ld_pc     = 1'b1;
      end
      StFetch2, StLdr2: begin
        mio_en = 1'b1;
        mem_oe = 1'b1;
        ld_mdr = mem_last;  // capture read data only once it is valid
      end
      StFetch3: begin
        bus_sel = BusMdr;
        ld_ir   = 1'b1;
      end
      StDecode: ld_ben = 1'b1;
      StAdd, StAnd: begin
        sr1mux_sel = 1'b1;
        sr2mux_sel = ir[5];
        aluk       = (state_q == StAnd) ? AluAnd : AluAdd;
        bus_sel    = BusAlu;
        drmux_sel  = 1'b0;
        ld_reg     = 1'b1;
        ld_cc      = 1'b1;
      end
      StNot: begin
        sr1mux_sel = 1'b1;
        aluk       = AluNot;
        bus_sel    = BusAlu;
        ld_reg     = 1'b1;
        ld_cc      = 1'b1;
      end
      StBr2: begin
        addr1mux_sel = 1'b0;
        addr2mux_sel = Addr2Off9;
        pcmux_sel    = PcAdder;
        ld_pc        = 1'b1;
      end
      StJmp: begin
        sr1mux_sel   = 1'b1;
        addr1mux_sel = 1'b1;
        addr2mux_sel = Addr2Zero;
        pcmux_sel    = PcAdder;
        ld_pc        = 1'b1;
      end
      StJsr1: begin
        bus_sel   = BusPc;
        drmux_sel = 1'b1;
        ld_reg    = 1'b1;
      end
      StJsr2: begin
        addr1mux_sel = 1'b0;
        addr2mux_sel = Addr2Off11;
        pcmux_sel    = PcAdder;
        ld_pc        = 1'b1;
      end
      StMemAddr: begin
        sr1mux_sel   = 1'b1;
        addr1mux_sel = 1'b1;
        addr2mux_sel = Addr2Off6;
        bus_sel      = BusMarmux;
        ld_mar       = 1'b1;
      end
      StLdr3: begin
        bus_sel   = BusMdr;
        drmux_sel = 1'b0;
        ld_reg    = 1'b1;
        ld_cc     = 1'b1;
      end
      StStr2: begin
        sr1mux_sel = 1'b0;
        aluk       = AluPass;
        bus_sel    = BusAlu;
        mio_en     = 1'b0;
        ld_mdr     = 1'b1;
      end
      StStr3:   mem_we = 1'b1;
      StPause1: ld_led = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lc3_control.sv
// Directed testbench for lc3_control with MEM_WAIT = 3.
// Control outputs are packed into one 25-bit word and compared each cycle
// against hand-built per-state words.
module tb_lc3_control;

  localparam int unsigned MEM_WAIT = 3;

  // Packed word layout: {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led,
  //   bus_sel[3:0], pcmux_sel[1:0], drmux, sr1mux, sr2mux, addr1mux, addr2mux[1:0],
  //   aluk[1:0], mio_en, mem_oe, mem_we}
  localparam logic [24:0] C_ZERO = 25'd0;
  localparam logic [24:0] C_F1   = {8'b1000_0010, 4'b0001, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00, 3'b000};
  localparam logic [24:0] C_F2   = {8'b0000_0000, 4'b0000, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00, 3'b110};
  localparam logic [24:0] C_F2L  = {8'b0100_0000, 4'b0000, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00, 3'b110};
  localparam logic [24:0] C_F3   = {8'b0010_0000, 4'b0100, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00, 3'b000};
  localparam logic [24:0] C_DEC  = {8'b0001_0000, 4'b0000, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00, 3'b000};
  localparam logic [24:0] C_ADD  = {8'b0000_1100, 4'b0010, 2'b00, 3'b010, 1'b0, 2'b00, 2'b00, 3'b000};
  localparam logic [24:0] C_ANDI = {8'b0000_1100, 4'b0010, 2'b00, 3'b011, 1'b0, 2'b00, 2'b01, 3'b000};
  localparam logic [24:0] C_NOT  = {8'b0000_1100, 4'b0010, 2'b00, 3'b010, 1'b0, 2'b00, 2'b10, 3'b000};
  localparam logic [24:0] C_BR2  = {8'b0000_0010, 4'b0000, 2'b10, 3'b000, 1'b0, 2'b10, 2'b00, 3'b000};
  localparam logic [24:0] C_JMP  = {8'b0000_0010, 4'b0000, 2'b10, 3'b010, 1'b1, 2'b00, 2'b00, 3'b000};
  localparam logic [24:0] C_JSR1 = {8'b0000_0100, 4'b0001, 2'b00, 3'b100, 1'b0, 2'b00, 2'b00, 3'b000};
  localparam logic [24:0] C_JSR2 = {8'b0000_0010, 4'b0000, 2'b10, 3'b000, 1'b0, 2'b11, 2'b00, 3'b000};
  localparam logic [24:0] C_MADR = {8'b1000_0000, 4'b1000, 2'b00, 3'b010, 1'b1, 2'b01, 2'b00, 3'b000};
  localparam logic [24:0] C_LDR3 = {8'b0000_1100, 4'b0100, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00, 3'b000};
  localparam logic [24:0] C_STR2 = {8'b0100_0000, 4'b0010, 2'b00, 3'b000, 1'b0, 2'b00, 2'b11, 3'b000};
  localparam logic [24:0] C_STR3 = {8'b0000_0000, 4'b0000, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00, 3'b001};
  localparam logic [24:0] C_LED  = {8'b0000_0001, 4'b0000, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00, 3'b000};

  logic        clk = 1'b0;
  logic        reset, run, continue_i, ben;
  logic [15:0] ir;
  logic        ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
  logic [3:0]  bus_sel;
  logic [1:0]  pcmux_sel, addr2mux_sel, aluk;
  logic        drmux_sel, sr1mux_sel, sr2mux_sel, addr1mux_sel;
  logic        mio_en, mem_oe, mem_we;
  logic [24:0] ctl;

  int checks = 0;
  int errors = 0;

  lc3_control #(.MEM_WAIT(MEM_WAIT)) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .continue_i   (continue_i),
    .ir           (ir),
    .ben          (ben),
    .ld_mar       (ld_mar),
    .ld_mdr       (ld_mdr),
    .ld_ir        (ld_ir),
    .ld_ben       (ld_ben),
    .ld_cc        (ld_cc),
    .ld_reg       (ld_reg),
    .ld_pc        (ld_pc),
    .ld_led       (ld_led),
    .bus_sel      (bus_sel),
    .pcmux_sel    (pcmux_sel),
    .drmux_sel    (drmux_sel),
    .sr1mux_sel   (sr1mux_sel),
    .sr2mux_sel   (sr2mux_sel),
    .addr1mux_sel (addr1mux_sel),
    .addr2mux_sel (addr2mux_sel),
    .aluk         (aluk),
    .mio_en       (mio_en),
    .mem_oe       (mem_oe),
    .mem_we       (mem_we)
  );

  assign ctl = {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led, bus_sel, pcmux_sel,
                drmux_sel, sr1mux_sel, sr2mux_sel, addr1mux_sel, addr2mux_sel, aluk,
                mio_en, mem_oe, mem_we};

  initial forever #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  // Advance one cycle; sampling happens 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int oe_cnt;
    ir = 16'h1283; ben = 1'b0; continue_i = 1'b0; run = 1'b1; reset = 1'b0;
    tick();
    tick();
    checks++;
    if (ctl !== C_ZERO) begin
      errors++; $display("FAIL reset_halted: got %07h want %07h", ctl, C_ZERO);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (ctl !== C_F1) begin
      errors++; $display("FAIL reset_fetch1: got %07h want %07h", ctl, C_F1);
    end
    oe_cnt = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (mem_oe === 1'b1) oe_cnt++;
    end
    checks++;
    if (oe_cnt != 3) begin
      errors++; $display("FAIL reset_mem_oe_cycles: got %0d want 3", oe_cnt);
    end
    tick();
    tick();
    checks++;
    if (ctl !== C_F1) begin
      errors++; $display("FAIL reset_next_fetch1: got %07h want %07h", ctl, C_F1);
    end
  endtask

  task automatic test_alu();
    logic [24:0] e_add [8];
    logic [24:0] e_and [8];
    logic [24:0] e_not [8];
    e_add = '{C_F1, C_F2, C_F2, C_F2L, C_F3, C_DEC, C_ADD, C_F1};
    e_and = '{C_F1, C_F2, C_F2, C_F2L, C_F3, C_DEC, C_ANDI, C_F1};
    e_not = '{C_F1, C_F2, C_F2, C_F2L, C_F3, C_DEC, C_NOT, C_F1};
    ir = 16'h1283;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ctl !== e_add[i]) begin
        errors++; $display("FAIL add cycle %0d: got %07h want %07h", i, ctl, e_add[i]);
      end
      if (i < 7) tick();
    end
    ir = 16'h5262;  // AND R1,R1,#2
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ctl !== e_and[i]) begin
        errors++; $display("FAIL and_imm cycle %0d: got %07h want %07h", i, ctl, e_and[i]);
      end
      if (i < 7) tick();
    end
    ir = 16'h927F;  // NOT R1,R1
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ctl !== e_not[i]) begin
        errors++; $display("FAIL not cycle %0d: got %07h want %07h", i, ctl, e_not[i]);
      end
      if (i < 7) tick();
    end
  endtask

  task automatic test_branch();
    logic [24:0] e_tk [9];
    logic [24:0] e_nt [8];
    e_tk = '{C_F1, C_F2, C_F2, C_F2L, C_F3, C_DEC, C_ZERO, C_BR2, C_F1};
    e_nt = '{C_F1, C_F2, C_F2, C_F2L, C_F3, C_DEC, C_ZERO, C_F1};
    ir = 16'h0A05;
    ben = 1'b1;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (ctl !== e_tk[i]) begin
        errors++; $display("FAIL br_taken cycle %0d: got %07h want %07h", i, ctl, e_tk[i]);
      end
      if (i < 8) tick();
    end
    ben = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ctl !== e_nt[i]) begin
        errors++; $display("FAIL br_not_taken cycle %0d: got %07h want %07h", i, ctl, e_nt[i]);
      end
      if (i < 7) tick();
    end
  endtask

  task automatic test_jmp_nop();
    logic [24:0] e_jmp [8];
    logic [24:0] e_nop [7];
    e_jmp = '{C_F1, C_F2, C_F2, C_F2L, C_F3, C_DEC, C_JMP, C_F1};
    e_nop = '{C_F1, C_F2, C_F2, C_F2L, C_F3, C_DEC, C_F1};
    ir = 16'hC1C0;  // JMP R7
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ctl !== e_jmp[i]) begin
        errors++; $display("FAIL jmp cycle %0d: got %07h want %07h", i, ctl, e_jmp[i]);
      end
      if (i < 7) tick();
    end
    ir = 16'h8000;  // undefined opcode
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (ctl !== e_nop[i]) begin
        errors++; $display("FAIL nop cycle %0d: got %07h want %07h", i, ctl, e_nop[i]);
      end
      if (i < 6) tick();
    end
  endtask

  task automatic test_ldr_str();
    logic [24:0] e_ldr [13];
    logic [24:0] e_str [13];
    int we_cnt;
    e_ldr = '{C_F1, C_F2, C_F2, C_F2L, C_F3, C_DEC, C_MADR, C_F2, C_F2, C_F2L, C_LDR3,
              C_ZERO, C_F1};
    e_str = '{C_F1, C_F2, C_F2, C_F2L, C_F3, C_DEC, C_MADR, C_STR2, C_STR3, C_STR3, C_STR3,
              C_ZERO, C_F1};
    ir = 16'h6042;  // LDR R0,R1,#2
    for (int i = 0; i < 13; i++) begin
      checks++;
      if (i == 11) begin
        if ({mem_oe, mem_we} !== 2'b00) begin
          errors++; $display("FAIL ldr_tail cycle %0d: got %b want 00", i, {mem_oe, mem_we});
        end
      end else if (ctl !== e_ldr[i]) begin
        errors++; $display("FAIL ldr cycle %0d: got %07h want %07h", i, ctl, e_ldr[i]);
      end
      if (i < 12) tick();
    end
    ir = 16'h7042;  // STR R0,R1,#2
    we_cnt = 0;
    for (int i = 0; i < 13; i++) begin
      if (mem_we === 1'b1) we_cnt++;
      checks++;
      if (i == 11) begin
        if ({mem_oe, mem_we} !== 2'b00) begin
          errors++; $display("FAIL str_tail cycle %0d: got %b want 00", i, {mem_oe, mem_we});
        end
      end else if (ctl !== e_str[i]) begin
        errors++; $display("FAIL str cycle %0d: got %07h want %07h", i, ctl, e_str[i]);
      end
      if (i < 12) tick();
    end
    checks++;
    if (we_cnt != 3) begin
      errors++; $display("FAIL str_mem_we_cycles: got %0d want 3", we_cnt);
    end
  endtask

  task automatic test_jsr_pause();
    logic [24:0] e_jsr [9];
    logic [24:0] e_p1  [12];
    logic [24:0] e_p2  [9];
    e_jsr = '{C_F1, C_F2, C_F2, C_F2L, C_F3, C_DEC, C_JSR1, C_JSR2, C_F1};
    e_p1  = '{C_F1, C_F2, C_F2, C_F2L, C_F3, C_DEC, C_LED, C_LED, C_LED, C_ZERO, C_ZERO, C_F1};
    e_p2  = '{C_F1, C_F2, C_F2, C_F2L, C_F3, C_DEC, C_LED, C_ZERO, C_F1};
    ir = 16'h4803;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (ctl !== e_jsr[i]) begin
        errors++; $display("FAIL jsr cycle %0d: got %07h want %07h", i, ctl, e_jsr[i]);
      end
      if (i < 8) tick();
    end
    ir = 16'hD0FF;
    continue_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (ctl !== e_p1[i]) begin
        errors++; $display("FAIL pause cycle %0d: got %07h want %07h", i, ctl, e_p1[i]);
      end
      if (i == 8) continue_i = 1'b1;
      if (i == 10) continue_i = 1'b0;
      if (i < 11) tick();
    end
    // continue already high when PAUSE is entered
    continue_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (ctl !== e_p2[i]) begin
        errors++; $display("FAIL pause_early cycle %0d: got %07h want %07h", i, ctl, e_p2[i]);
      end
      if (i == 7) continue_i = 1'b0;
      if (i < 8) tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [24:0] e_ldr [9];
    logic [24:0] e_str [10];
    logic [24:0] e_add [7];
    e_ldr = '{C_F1, C_F2, C_F2, C_F2L, C_F3, C_DEC, C_MADR, C_F2, C_F2};
    e_str = '{C_F1, C_F2, C_F2, C_F2L, C_F3, C_DEC, C_MADR, C_STR2, C_STR3, C_STR3};
    e_add = '{C_F1, C_F2, C_F2, C_F2L, C_F3, C_DEC, C_ADD};
    ir = 16'h6042;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (ctl !== e_ldr[i]) begin
        errors++; $display("FAIL rst_ldr cycle %0d: got %07h want %07h", i, ctl, e_ldr[i]);
      end
      if (i < 8) tick();
    end
    reset = 1'b0;  // second cycle of LDR2
    tick();
    checks++;
    if (ctl !== C_ZERO) begin
      errors++; $display("FAIL rst_ldr_halted: got %07h want %07h", ctl, C_ZERO);
    end
    reset = 1'b1;
    tick();
    ir = 16'h7042;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (ctl !== e_str[i]) begin
        errors++; $display("FAIL rst_str cycle %0d: got %07h want %07h", i, ctl, e_str[i]);
      end
      if (i < 9) tick();
    end
    reset = 1'b0;  // mid STR3 with mem_we high
    tick();
    checks++;
    if (ctl !== C_ZERO) begin
      errors++; $display("FAIL rst_str_halted: got %07h want %07h", ctl, C_ZERO);
    end
    reset = 1'b1;
    run = 1'b0;
    tick();
    checks++;
    if (ctl !== C_ZERO) begin
      errors++; $display("FAIL run_low_stays_halted: got %07h want %07h", ctl, C_ZERO);
    end
    run = 1'b1;
    tick();
    ir = 16'h1283;
    run = 1'b0;  // dropped mid-instruction, sampled only at its end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (ctl !== e_add[i]) begin
        errors++; $display("FAIL run_low_add cycle %0d: got %07h want %07h", i, ctl, e_add[i]);
      end
      tick();
    end
    checks++;
    if (ctl !== C_ZERO) begin
      errors++; $display("FAIL run_low_end_halted: got %07h want %07h", ctl, C_ZERO);
    end
    tick();
    checks++;
    if (ctl !== C_ZERO) begin
      errors++; $display("FAIL run_low_hold_halted: got %07h want %07h", ctl, C_ZERO);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_jmp_nop();
    test_ldr_str();
    test_jsr_pause();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
